morse_encoder: RTL and testbench
================================

Name: morse_encoder

Overview:
- Transmit-side counterpart of the team's Morse decoder: accepts ASCII characters over a valid/ready handshake and emits them as Morse symbol strobes on the decoder's input interface.
- That interface is dot, dash, lg (letter gap), wg (word gap) and valid.
- Sits between a character source (host/UART FIFO) and the decoder or a keying stage. Output is loopback-compatible with the decoder.

Parameters:
- GAP_CYCLES, 1, idle cycles (valid low) inserted after every element strobe before the next strobe; legal range 0..255.

Ports:
- clk  input  1  clock, all logic on rising edge
- clr  input  1  synchronous active-high reset
- din  input  8  ASCII character to send
- din_valid  input  1  din holds a character
- din_ready  output  1  encoder can accept; transfer when din_valid && din_ready at a rising edge
- dot  output  1  element is a dot (qualified by valid)
- dash  output  1  element is a dash (qualified by valid)
- lg  output  1  letter-gap marker (qualified by valid)
- wg  output  1  word-gap marker (qualified by valid)
- valid  output  1  one-cycle strobe; exactly one of dot/dash/lg/wg is high when valid=1, all four are 0 otherwise
- error  output  1  one-cycle pulse: accepted character unsupported

Behaviour:
- Reset:
  - clr is sampled at the rising edge of clk.
  - While clr=1, and in the cycle after it, dot=dash=lg=wg=valid=error=0, state=IDLE, counters=0.
  - din_ready = (state==IDLE) && !clr, so it is 0 while clr is high.
  - clr mid-character aborts the character: no further strobes, no lg.
- Code table (combinational ROM, 3-bit length 1..5, 5-bit pattern, MSB-first, 1=dash). Supported characters:
  - Letters: 'A'-'Z' (65-90); lowercase 'a'-'z' (97-122) map to uppercase.
  - Digits: '0'-'9' (48-57).
  - Punctuation: '=' (61) -...-, '/' (47) -..-., '+' (43) .-.-.
  - Space: ' ' (32) is a word gap.
  - Patterns follow standard ITU Morse, e.g. A=.-, Q=--.-, 0=-----, 5=.....
- FSM states: IDLE, ELEM, EGAP, LGAP.
  - IDLE, on accept: capture din into a char register, look up length/pattern, set element index=0.
    - Letter/digit/punctuation → ELEM.
    - Space → emit wg strobe next cycle, return to IDLE.
    - Unsupported → error pulse next cycle, no symbol strobes, return to IDLE.
  - ELEM: drive one strobe (dot or dash per pattern bit), then increment the index.
    - If GAP_CYCLES>0 → EGAP.
    - Otherwise → next ELEM, or LGAP after the last element.
  - EGAP: count GAP_CYCLES idle cycles, then go to ELEM, or to LGAP if all elements are sent.
  - LGAP: drive one lg strobe → IDLE.
- Timing, with the accept at edge k (all outputs registered):
  - Element i strobe in cycle k+1+i*(GAP_CYCLES+1).
  - lg strobe in cycle k+1+len*(GAP_CYCLES+1).
  - din_ready high in the cycle after the lg strobe.
  - Space: wg in cycle k+1, ready in cycle k+2.
  - Error: error in cycle k+1, ready in cycle k+2.
- din and din_valid are ignored while din_ready=0. The captured character is immune to later din changes.
- Every character ends with exactly one lg strobe; space produces only wg (no lg).
- Back-to-back characters are allowed, limited by din_ready, with no extra idle cycles beyond the above.
- error and valid are never high in the same cycle.

Test Plan:
- Reset: hold clr 3 cycles with din_valid=1, din=65 → din_ready=0 and all outputs 0 throughout; din_ready=1 the first cycle after clr drops.
- 'E' (69), GAP_CYCLES=1, accept at cycle 0 → dot+valid at cycle 1; idle at 2; lg+valid at 3; din_ready=1 at 4; 'e' (101) gives an identical trace.
- '0' (48), GAP_CYCLES=0 → dash strobes on 5 consecutive cycles 1-5; lg at 6; ready at 7.
- Stream "SOS " (83,79,83,32), GAP_CYCLES=1 → strobe sequence . . . lg - - - lg . . . lg wg; feed it into the decoder → dout 83,79,83,32 each with dvalid.
- Unsupported '#' (35) then 'T' (84) → error=1 for one cycle at k+1 with valid=0; 'T' is accepted at k+2 and yields dash then lg.
- clr asserted during the 3rd element of 'Q' → no further strobes and no lg; after release, 'K' (75) encodes cleanly as -.- lg.

Source files
------------

// File: rtl/morse_encoder.sv
// morse_encoder: accepts ASCII characters over a valid/ready handshake and
// emits each one as Morse element strobes (dot/dash), followed by a
// letter-gap strobe. A space emits a single word-gap strobe. Unsupported
// characters produce a one-cycle error pulse. The output is loopback-compatible
// with the Morse decoder.
module morse_encoder #(
  parameter int unsigned GAP_CYCLES = 1
) (
  input  logic       clk,
  input  logic       clr,
  input  logic [7:0] din,
  input  logic       din_valid,
  output logic       din_ready,
  output logic       dot,
  output logic       dash,
  output logic       lg,
  output logic       wg,
  output logic       valid,
  output logic       error
);

  typedef enum logic [1:0] {IDLE, ELEM, EGAP, LGAP} state_t;

  localparam bit         HAS_GAP  = (GAP_CYCLES != 0);
  localparam logic [7:0] GAP_LAST = 8'((GAP_CYCLES != 0) ? GAP_CYCLES - 1 : 0);

  state_t     state_q;
  logic [2:0] len_q;
  logic [2:0] idx_q;
  logic [2:0] idx_d;
  logic [4:0] pat_q;
  logic [7:0] cnt_q;
  logic       dot_q, dash_q, lg_q, wg_q, valid_q, error_q;

  logic [7:0] uc;
  logic [7:0] rom;
  logic [2:0] rom_len;
  logic [4:0] rom_pat;
  logic       is_space;
  logic       last_d;

  // Fold lowercase to uppercase and look up {length, left-aligned pattern}; 1=dash
  always_comb begin
    uc = din;
    if (din >= 8'd97 && din <= 8'd122) uc = din - 8'd32;
    is_space = (din == 8'd32);
    rom = '0;
    case (uc)
      8'd65: rom = {3'd2, 5'b01000}; // A .-
      8'd66: rom = {3'd4, 5'b10000}; // B -...
      8'd67: rom = {3'd4, 5'b10100}; // C -.-.
      8'd68: rom = {3'd3, 5'b10000}; // D -..
      8'd69: rom = {3'd1, 5'b00000}; // E .
      8'd70: rom = {3'd4, 5'b00100}; // F ..-.
      8'd71: rom = {3'd3, 5'b11000}; // G --.
      8'd72: rom = {3'd4, 5'b00000}; // H ....
      8'd73: rom = {3'd2, 5'b00000}; // I ..
      8'd74: rom = {3'd4, 5'b01110}; // J .---
      8'd75: rom = {3'd3, 5'b10100}; // K -.-
      8'd76: rom = {3'd4, 5'b01000}; // L .-..
      8'd77: rom = {3'd2, 5'b11000}; // M --
      8'd78: rom = {3'd2, 5'b10000}; // N -.
      8'd79: rom = {3'd3, 5'b11100}; // O ---
      8'd80: rom = {3'd4, 5'b01100}; // P .--.
      8'd81: rom = {3'd4, 5'b11010}; // Q --.-
      8'd82: rom = {3'd3, 5'b01000}; // R .-.
      8'd83: rom = {3'd3, 5'b00000}; // S ...
      8'd84: rom = {3'd1, 5'b10000}; // T -
      8'd85: rom = {3'd3, 5'b00100}; // U ..-
      8'd86: rom = {3'd4, 5'b00010}; // V ...-
      8'd87: rom = {3'd3, 5'b01100}; // W .--
      8'd88: rom = {3'd4, 5'b10010}; // X -..-
      8'd89: rom = {3'd4, 5'b10110}; // Y -.--
      8'd90: rom = {3'd4, 5'b11000}; // Z --..
      8'd48: rom = {3'd5, 5'b11111}; // 0 -----
      8'd49: rom = {3'd5, 5'b01111}; // 1 .----
      8'd50: rom = {3'd5, 5'b00111}; // 2 ..---
      8'd51: rom = {3'd5, 5'b00011}; // 3 ...--
      8'd52: rom = {3'd5, 5'b00001}; // 4 ....-
      8'd53: rom = {3'd5, 5'b00000}; // 5 .....
      8'd54: rom = {3'd5, 5'b10000}; // 6 -....
      8'd55: rom = {3'd5, 5'b11000}; // 7 --...
      8'd56: rom = {3'd5, 5'b11100}; // 8 ---..
      8'd57: rom = {3'd5, 5'b11110}; // 9 ----.
      8'd61: rom = {3'd5, 5'b10001}; // = -...-
      8'd47: rom = {3'd5, 5'b10010}; // / -..-.
      8'd43: rom = {3'd5, 5'b01010}; // + .-.-.
      default: rom = '0;
    endcase
    rom_len = rom[7:5];
    rom_pat = rom[4:0];
  end

  // Element index after the strobe currently being sent
  always_comb begin
    idx_d  = idx_q + 3'd1;
    last_d = (idx_d == len_q);
  end

  assign din_ready = (state_q == IDLE) && !clr;
  assign dot       = dot_q;
  assign dash      = dash_q;
  assign lg        = lg_q;
  assign wg        = wg_q;
  assign valid     = valid_q;
  assign error     = error_q;

  // Sequencer: outputs are registered and set on the edge that enters the
  // cycle they belong to. pat_q always holds the next element in bit 4.
  // LGAP is the single terminal-strobe cycle before IDLE; space (wg) and
  // error reuse it so that ready returns two cycles after accept.
  always_ff @(posedge clk) begin
    if (clr) begin
      state_q <= IDLE;
      len_q   <= '0;
      idx_q   <= '0;
      pat_q   <= '0;
      cnt_q   <= '0;
      dot_q   <= 1'b0;
      dash_q  <= 1'b0;
      lg_q    <= 1'b0;
      wg_q    <= 1'b0;
      valid_q <= 1'b0;
      error_q <= 1'b0;
    end else begin
      dot_q   <= 1'b0;
      dash_q  <= 1'b0;
      lg_q    <= 1'b0;
      wg_q    <= 1'b0;
      valid_q <= 1'b0;
      error_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (din_valid) begin
            if (is_space) begin
              wg_q    <= 1'b1;
              valid_q <= 1'b1;
              state_q <= LGAP;
            end else if (rom_len == 3'd0) begin
              error_q <= 1'b1;
              state_q <= LGAP;
            end else begin
              len_q   <= rom_len;
              idx_q   <= '0;
              cnt_q   <= '0;
              pat_q   <= {rom_pat[3:0], 1'b0};
              dot_q   <= ~rom_pat[4];
              dash_q  <= rom_pat[4];
              valid_q <= 1'b1;
              state_q <= ELEM;
            end
          end
        end
        ELEM: begin
          idx_q <= idx_d;
          cnt_q <= '0;
          if (HAS_GAP) begin
            state_q <= EGAP;
          end else if (last_d) begin
            lg_q    <= 1'b1;
            valid_q <= 1'b1;
            state_q <= LGAP;
          end else begin
            dot_q   <= ~pat_q[4];
            dash_q  <= pat_q[4];
            valid_q <= 1'b1;
            pat_q   <= {pat_q[3:0], 1'b0};
            state_q <= ELEM;
          end
        end
        EGAP: begin
          if (cnt_q == GAP_LAST) begin
            if (idx_q == len_q) begin
              lg_q    <= 1'b1;
              valid_q <= 1'b1;
              state_q <= LGAP;
            end else begin
              dot_q   <= ~pat_q[4];
              dash_q  <= pat_q[4];
              valid_q <= 1'b1;
              pat_q   <= {pat_q[3:0], 1'b0};
              state_q <= ELEM;
            end
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        LGAP: begin
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_morse_encoder.sv
// tb_morse_encoder: three encoders with different gap lengths driven from
// per-instance character queues and checked cycle by cycle against a model
// that expands each accepted character from a Morse string table, plus a
// loopback decode of the strobes back into characters.
module tb_morse_encoder;

  localparam int NDUT = 3;
  localparam int unsigned GAPV [NDUT] = '{0, 1, 3};

  // {error, wg, lg, dash, dot, valid}
  localparam logic [5:0] V_DOT  = 6'b000011;
  localparam logic [5:0] V_DASH = 6'b000101;
  localparam logic [5:0] V_LG   = 6'b001001;
  localparam logic [5:0] V_WG   = 6'b010001;
  localparam logic [5:0] V_ERR  = 6'b100000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       clr;
  logic [7:0] din    [NDUT];
  logic       dv     [NDUT];
  logic       rdy    [NDUT];
  logic       dot_w  [NDUT];
  logic       dash_w [NDUT];
  logic       lg_w   [NDUT];
  logic       wg_w   [NDUT];
  logic       val_w  [NDUT];
  logic       err_w  [NDUT];

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    morse_encoder #(.GAP_CYCLES(GAPV[g])) u_dut (
      .clk       (clk),
      .clr       (clr),
      .din       (din[g]),
      .din_valid (dv[g]),
      .din_ready (rdy[g]),
      .dot       (dot_w[g]),
      .dash      (dash_w[g]),
      .lg        (lg_w[g]),
      .wg        (wg_w[g]),
      .valid     (val_w[g]),
      .error     (err_w[g])
    );
  end

  int total = 0;
  int bad   = 0;

  logic [5:0] expq  [NDUT][$];
  logic [7:0] decq  [NDUT][$];
  logic [7:0] sendq [NDUT][$];
  string      partial [NDUT];
  logic       rdy_m [NDUT];
  logic       clr_next;
  bit         rnd_mode;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] upcase(input logic [7:0] c);
    return (c >= 8'd97 && c <= 8'd122) ? c - 8'd32 : c;
  endfunction

  function automatic string morse_of(input logic [7:0] c);
    case (upcase(c))
      "A": return ".-";    "B": return "-...";  "C": return "-.-.";
      "D": return "-..";   "E": return ".";     "F": return "..-.";
      "G": return "--.";   "H": return "....";  "I": return "..";
      "J": return ".---";  "K": return "-.-";   "L": return ".-..";
      "M": return "--";    "N": return "-.";    "O": return "---";
      "P": return ".--.";  "Q": return "--.-";  "R": return ".-.";
      "S": return "...";   "T": return "-";     "U": return "..-";
      "V": return "...-";  "W": return ".--";   "X": return "-..-";
      "Y": return "-.--";  "Z": return "--..";
      "0": return "-----"; "1": return ".----"; "2": return "..---";
      "3": return "...--"; "4": return "....-"; "5": return ".....";
      "6": return "-...."; "7": return "--..."; "8": return "---..";
      "9": return "----.";
      "=": return "-...-"; "/": return "-..-."; "+": return ".-.-.";
      default: return "";
    endcase
  endfunction

  function automatic logic [7:0] decode(input string s);
    if (s.len() == 0) return 8'h3F;
    for (int c = 33; c <= 90; c++)
      if (morse_of(8'(c)) == s) return 8'(c);
    return 8'h3F;
  endfunction

  function automatic logic [7:0] rand_char();
    case ($urandom_range(0, 9))
      3: return 8'(97 + $urandom_range(0, 25));
      4: return 8'(48 + $urandom_range(0, 9));
      5: case ($urandom_range(0, 2))
           0: return 8'd61;
           1: return 8'd47;
           default: return 8'd43;
         endcase
      6: return 8'd32;
      7: return 8'($urandom_range(0, 255));
      default: return 8'(65 + $urandom_range(0, 25));
    endcase
  endfunction

  // Expand one accepted character into its per-cycle output trace
  task automatic model_push(input int d, input logic [7:0] c);
    string s;
    s = morse_of(c);
    if (c == 8'd32) begin
      expq[d].push_back(V_WG);
      decq[d].push_back(8'd32);
    end else if (s.len() == 0) begin
      expq[d].push_back(V_ERR);
    end else begin
      for (int i = 0; i < s.len(); i++) begin
        expq[d].push_back((s.getc(i) == "-") ? V_DASH : V_DOT);
        for (int j = 0; j < int'(GAPV[d]); j++) expq[d].push_back('0);
      end
      expq[d].push_back(V_LG);
      decq[d].push_back(upcase(c));
    end
  endtask

  task automatic cycle();
    logic [5:0] got, exp;
    logic [7:0] c, e;
    @(posedge clk);
    for (int d = 0; d < NDUT; d++) begin
      if (expq[d].size() > 0) void'(expq[d].pop_front());
      if (clr) begin
        expq[d].delete();
        decq[d].delete();
        partial[d] = "";
      end else if (dv[d] && rdy_m[d]) begin
        model_push(d, din[d]);
        if (sendq[d].size() > 0) void'(sendq[d].pop_front());
      end
    end
    @(negedge clk);
    clr = clr_next;
    for (int d = 0; d < NDUT; d++) begin
      if (sendq[d].size() > 0 && (!rnd_mode || $urandom_range(0, 9) < 7)) begin
        din[d] = sendq[d][0];
        dv[d]  = 1'b1;
      end else begin
        din[d] = 8'($urandom);
        dv[d]  = 1'b0;
      end
    end
    #1;
    for (int d = 0; d < NDUT; d++) begin
      got = {err_w[d], wg_w[d], lg_w[d], dash_w[d], dot_w[d], val_w[d]};
      exp = (expq[d].size() > 0) ? expq[d][0] : '0;
      rdy_m[d] = (expq[d].size() == 0) && !clr;
      chk($sformatf("outs_gap%0d", GAPV[d]), 32'(got), 32'(exp));
      chk($sformatf("ready_gap%0d", GAPV[d]), 32'(rdy[d]), 32'(rdy_m[d]));
      if (val_w[d]) begin
        if (dot_w[d]) partial[d] = {partial[d], "."};
        else if (dash_w[d]) partial[d] = {partial[d], "-"};
        else if (lg_w[d] || wg_w[d]) begin
          c = wg_w[d] ? 8'd32 : decode(partial[d]);
          partial[d] = "";
          e = (decq[d].size() > 0) ? decq[d].pop_front() : 8'h00;
          chk($sformatf("loopback_gap%0d", GAPV[d]), 32'(c), 32'(e));
        end
      end
    end
  endtask

  function automatic bit all_idle();
    for (int d = 0; d < NDUT; d++)
      if (sendq[d].size() != 0 || expq[d].size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  function automatic bit all_sent();
    for (int d = 0; d < NDUT; d++)
      if (sendq[d].size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic drain(input string tag, input int budget);
    int n;
    n = 0;
    while (!all_idle() && n < budget) begin
      cycle();
      n++;
    end
    if (!all_idle()) chk(tag, 32'd0, 32'd1);
  endtask

  task automatic push_all(input string s);
    for (int d = 0; d < NDUT; d++)
      for (int i = 0; i < s.len(); i++) sendq[d].push_back(8'(s.getc(i)));
  endtask

  initial begin
    string dir;
    int n;
    clr      = 1'b1;
    clr_next = 1'b1;
    rnd_mode = 1'b0;
    for (int d = 0; d < NDUT; d++) begin
      din[d]     = 8'd65;
      dv[d]      = 1'b1;
      rdy_m[d]   = 1'b0;
      partial[d] = "";
      sendq[d].push_back(8'd65);
    end

    // Reset held for three edges with a character pending
    cycle();
    cycle();
    clr_next = 1'b0;
    cycle();
    drain("drain_reset", 200);

    // Directed characters: lowercase, digits, punctuation, space, unsupported
    dir = "EeOSOS #Ta5=/+0";
    push_all(dir);
    drain("drain_directed", 2000);

    // Abort 'Q' mid-character, then send 'K'
    push_all("Q");
    n = 0;
    while (!all_sent() && n < 50) begin
      cycle();
      n++;
    end
    if (!all_sent()) chk("accept_q", 32'd0, 32'd1);
    repeat (3) cycle();
    clr_next = 1'b1;
    repeat (2) cycle();
    clr_next = 1'b0;
    push_all("K");
    drain("drain_abort", 200);

    // Random characters with sparse valid and occasional reset
    rnd_mode = 1'b1;
    for (int d = 0; d < NDUT; d++)
      for (int i = 0; i < 100; i++) sendq[d].push_back(rand_char());
    n = 0;
    while (!all_sent() && n < 20000) begin
      clr_next = ($urandom_range(0, 149) == 0);
      cycle();
      n++;
    end
    if (!all_sent()) chk("random_send", 32'd0, 32'd1);
    clr_next = 1'b0;
    drain("drain_random", 500);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
